// File: rtl/shrimp_pkg.sv
// Shared types and sizes for the shrimp operand-fetch stage.
//   DATA_W / REG_ADDR_W / NUM_REGS / OP_W : datapath and register-file sizing
//   word_t, reg_addr_t, op_t              : scalar field types
//   fetch_bundle_t                        : contents of the output slot to execute
//   addr_hit()                            : qualified address match helper
package shrimp_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;
  localparam int OP_W       = 8;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [OP_W-1:0]       op_t;

  typedef struct packed {
    word_t     a;
    word_t     b;
    reg_addr_t rd;
    logic      rd_en;
    op_t       op;
  } fetch_bundle_t;

  // True when an enabled port addresses register y.
  function automatic logic addr_hit(input logic en, input reg_addr_t x, input reg_addr_t y);
    return en && (x == y);
  endfunction

endpackage

// File: rtl/shrimp_scoreboard.sv
// Register busy scoreboard for the shrimp operand-fetch stage.
//   clock, reset_n          : clock, asynchronous active-low reset
//   set_en / set_addr       : mark a register busy (an instruction was accepted)
//   clr_en / clr_addr       : write-back completed, register no longer busy
//   rel_en / rel_addr       : flushed instruction released its destination
//   look_a / look_b / look_d: three lookup addresses
//   eff_a / eff_b / eff_d   : effective busy for each lookup (same-cycle
//                             write-back already taken into account)
module shrimp_scoreboard
  import shrimp_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic                  rel_en,
  input  logic [REG_ADDR_W-1:0] rel_addr,
  input  logic [REG_ADDR_W-1:0] look_a,
  input  logic [REG_ADDR_W-1:0] look_b,
  input  logic [REG_ADDR_W-1:0] look_d,
  output logic                  eff_a,
  output logic                  eff_b,
  output logic                  eff_d
);

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic [NUM_REGS-1:0] busy_eff;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      logic set_hit;
      logic clr_hit;
      logic rel_hit;
      assign set_hit = addr_hit(set_en, set_addr, reg_addr_t'(gi));
      assign clr_hit = addr_hit(clr_en, clr_addr, reg_addr_t'(gi));
      assign rel_hit = addr_hit(rel_en, rel_addr, reg_addr_t'(gi));
      // A new writer accepted in the same cycle its predecessor retires must
      // stay busy, so set dominates both kinds of clear.
      assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit & ~rel_hit);
      // Only a write-back unblocks readers this cycle; its value is bypassed.
      assign busy_eff[gi]  = busy_reg[gi] & ~clr_hit;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign eff_a = busy_eff[look_a];
  assign eff_b = busy_eff[look_b];
  assign eff_d = busy_eff[look_d];

endmodule

// File: rtl/shrimp_operand_fetch.sv
// Operand-fetch stage of the shrimp CPU (decode -> execute).
//   clock, reset_n               : clock, asynchronous active-low reset
//   in_valid/in_ready            : decoded instruction handshake
//   in_rs_a/in_rs_b/in_rd/in_rd_en/in_op : decoded instruction fields
//   reg_r_a_addr/reg_r_b_addr    : register-file read addresses
//   reg_r_a_val/reg_r_b_val      : register-file read data (combinational)
//   wb_valid/wb_addr/wb_val      : register-file write port, bypassed here
//   flush                        : discard the output slot
//   out_valid/out_ready          : operand bundle handshake to execute
//   out_a/out_b/out_rd/out_rd_en/out_op : registered operand bundle
module shrimp_operand_fetch
  import shrimp_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs_a,
  input  logic [REG_ADDR_W-1:0] in_rs_b,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_rd_en,
  input  logic [OP_W-1:0]       in_op,
  output logic [REG_ADDR_W-1:0] reg_r_a_addr,
  output logic [REG_ADDR_W-1:0] reg_r_b_addr,
  input  logic [DATA_W-1:0]     reg_r_a_val,
  input  logic [DATA_W-1:0]     reg_r_b_val,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_val,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_a,
  output logic [DATA_W-1:0]     out_b,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_rd_en,
  output logic [OP_W-1:0]       out_op
);

  fetch_bundle_t slot_reg;
  fetch_bundle_t slot_next;
  logic          out_valid_reg;

  word_t opnd_a;
  word_t opnd_b;
  logic  busy_a;
  logic  busy_b;
  logic  busy_d;
  logic  hazard;
  logic  accept;
  logic  release_en;

  // Register file is read unconditionally so the data is ready whenever the
  // instruction becomes acceptable.
  assign reg_r_a_addr = in_rs_a;
  assign reg_r_b_addr = in_rs_b;

  // Same-cycle write-back bypass: the register file only shows the new value
  // after the edge, so the write port is forwarded directly.
  assign opnd_a = addr_hit(wb_valid, wb_addr, in_rs_a) ? wb_val : reg_r_a_val;
  assign opnd_b = addr_hit(wb_valid, wb_addr, in_rs_b) ? wb_val : reg_r_b_val;

  // A flushed slot never writes back, so its destination is released here.
  assign release_en = flush && out_valid_reg && slot_reg.rd_en;

  shrimp_scoreboard u_scoreboard (
    .clock    (clock),
    .reset_n  (reset_n),
    .set_en   (accept && in_rd_en),
    .set_addr (in_rd),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .rel_en   (release_en),
    .rel_addr (slot_reg.rd),
    .look_a   (in_rs_a),
    .look_b   (in_rs_b),
    .look_d   (in_rd),
    .eff_a    (busy_a),
    .eff_b    (busy_b),
    .eff_d    (busy_d)
  );

  // Both sources are always read, so both are always checked (RAW); the
  // destination check (WAW) keeps one outstanding writer per register.
  assign hazard   = busy_a || busy_b || (in_rd_en && busy_d);
  assign in_ready = reset_n && !flush && !hazard && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    slot_next = '{a: opnd_a, b: opnd_b, rd: in_rd, rd_en: in_rd_en, op: in_op};
  end

  // Single output slot: contents change only on accept, so they hold stable
  // under back-pressure. Flush or consume without a new accept empties it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_reg      <= '0;
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      slot_reg      <= slot_next;
      out_valid_reg <= 1'b1;
    end else if (flush || out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_a     = slot_reg.a;
  assign out_b     = slot_reg.b;
  assign out_rd    = slot_reg.rd;
  assign out_rd_en = slot_reg.rd_en;
  assign out_op    = slot_reg.op;

endmodule

// File: tb/tb_shrimp_operand_fetch.sv
// Self-checking bench for shrimp_operand_fetch: directed vector table,
// hand-written reset sequences, and a randomized run against a reference model.
module tb_shrimp_operand_fetch;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rs_a;
  logic [3:0]  in_rs_b;
  logic [3:0]  in_rd;
  logic        in_rd_en;
  logic [7:0]  in_op;
  logic [3:0]  reg_r_a_addr;
  logic [3:0]  reg_r_b_addr;
  logic [15:0] reg_r_a_val;
  logic [15:0] reg_r_b_val;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_val;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [3:0]  out_rd;
  logic        out_rd_en;
  logic [7:0]  out_op;

  int n_cmp = 0;
  int n_err = 0;

  shrimp_operand_fetch dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rs_a      (in_rs_a),
    .in_rs_b      (in_rs_b),
    .in_rd        (in_rd),
    .in_rd_en     (in_rd_en),
    .in_op        (in_op),
    .reg_r_a_addr (reg_r_a_addr),
    .reg_r_b_addr (reg_r_b_addr),
    .reg_r_a_val  (reg_r_a_val),
    .reg_r_b_val  (reg_r_b_val),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_val       (wb_val),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_rd       (out_rd),
    .out_rd_en    (out_rd_en),
    .out_op       (out_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file model: reset contents are 0xA000 + index.
  logic [15:0] rf [16];
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'hA000 + 16'(i);
    end else if (wb_valid) begin
      rf[wb_addr] <= wb_val;
    end
  end
  assign reg_r_a_val = rf[reg_r_a_addr];
  assign reg_r_b_val = rf[reg_r_b_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [3:0]  ra, rb, rd;
    logic        rde;
    logic [7:0]  op;
    logic        wbv;
    logic [3:0]  wba;
    logic [15:0] wbd;
    logic        fl, ordy;
    logic        e_rdy, e_ov;
    logic [15:0] e_a, e_b;
    logic [7:0]  e_op;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [3:0] ra, input logic [3:0] rb,
                              input logic [3:0] rd, input logic rde, input logic [7:0] op,
                              input logic wbv, input logic [3:0] wba, input logic [15:0] wbd,
                              input logic fl, input logic ordy, input logic e_rdy, input logic e_ov,
                              input logic [15:0] e_a, input logic [15:0] e_b, input logic [7:0] e_op);
    vec_t v;
    v.iv = iv; v.ra = ra; v.rb = rb; v.rd = rd; v.rde = rde; v.op = op;
    v.wbv = wbv; v.wba = wba; v.wbd = wbd; v.fl = fl; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_a = e_a; v.e_b = e_b; v.e_op = e_op;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rd, input logic rde, input logic [7:0] op,
                       input logic wbv, input logic [3:0] wba, input logic [15:0] wbd,
                       input logic fl, input logic ordy);
    in_valid = iv; in_rs_a = ra; in_rs_b = rb; in_rd = rd; in_rd_en = rde; in_op = op;
    wb_valid = wbv; wb_addr = wba; wb_val = wbd; flush = fl; out_ready = ordy;
  endtask

  // Reference model state (spec-level view: busy set, slot, outstanding writers).
  bit          m_busy [16];
  logic        m_sv;
  logic [15:0] m_sa, m_sb;
  logic [3:0]  m_srd;
  logic        m_srde;
  logic [7:0]  m_sop;
  int          pend [$];

  vec_t tbl [30];

  initial begin
    int idx;
    int r;
    logic        iv, rde, wbv, fl, ordy, erdy, acc;
    logic [3:0]  ra, rb, rd, wba;
    logic [7:0]  op;
    logic [15:0] wbd, ea, eb;

    // Independent stream
    tbl[0]  = mk(1, 1, 2, 3, 1, 8'h01, 0, 0, 0, 0, 1, 1, 1, 16'hA001, 16'hA002, 8'h01);
    tbl[1]  = mk(1, 4, 5, 6, 1, 8'h02, 0, 0, 0, 0, 1, 1, 1, 16'hA004, 16'hA005, 8'h02);
    tbl[2]  = mk(1, 7, 8, 9, 1, 8'h03, 0, 0, 0, 0, 1, 1, 1, 16'hA007, 16'hA008, 8'h03);
    // RAW stall on r3 for four cycles, accepted in the write-back cycle (also rewrites r3)
    for (int i = 3; i < 7; i++) tbl[i] = mk(1, 3, 0, 3, 1, 8'h04, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 3, 0, 3, 1, 8'h04, 1, 3, 16'h1234, 0, 1, 1, 1, 16'h1234, 16'hA000, 8'h04);
    // r3 stays busy (set won over clear), bypass on operand b
    tbl[8]  = mk(1, 0, 3, 11, 0, 8'h05, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 3, 11, 0, 8'h05, 1, 3, 16'h5555, 0, 1, 1, 1, 16'hA000, 16'h5555, 8'h05);
    // WAW on r6, an unrelated write-back does not release it
    tbl[10] = mk(1, 1, 2, 6, 1, 8'h06, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, 2, 6, 1, 8'h06, 1, 9, 16'h9999, 0, 1, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 1, 2, 6, 1, 8'h06, 1, 6, 16'h6666, 0, 1, 1, 1, 16'hA001, 16'hA002, 8'h06);
    tbl[13] = mk(1, 6, 1, 12, 0, 8'h07, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 6, 1, 12, 0, 8'h07, 1, 6, 16'h7777, 0, 1, 1, 1, 16'h7777, 16'hA001, 8'h07);
    // Back-pressure for three cycles, then release
    for (int i = 15; i < 18; i++) tbl[i] = mk(1, 1, 2, 13, 0, 8'h08, 0, 0, 0, 0, 0, 0, 1, 16'h7777, 16'hA001, 8'h07);
    tbl[18] = mk(1, 1, 2, 13, 0, 8'h08, 0, 0, 0, 0, 1, 1, 1, 16'hA001, 16'hA002, 8'h08);
    // Flush of a slot writing r7, then the r7 reader goes straight through
    tbl[19] = mk(1, 4, 5, 7, 1, 8'h09, 0, 0, 0, 0, 1, 1, 1, 16'hA004, 16'hA005, 8'h09);
    tbl[20] = mk(1, 7, 1, 14, 0, 8'h0A, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[21] = mk(1, 7, 1, 14, 0, 8'h0A, 0, 0, 0, 0, 1, 1, 1, 16'hA007, 16'hA001, 8'h0A);
    // Flush plus write-back to the same register
    tbl[22] = mk(1, 1, 1, 8, 1, 8'h0B, 0, 0, 0, 0, 1, 1, 1, 16'hA001, 16'hA001, 8'h0B);
    tbl[23] = mk(0, 0, 0, 0, 0, 8'h00, 1, 8, 16'h8888, 1, 1, 0, 0, 0, 0, 0);
    tbl[24] = mk(1, 8, 0, 0, 0, 8'h0C, 0, 0, 0, 0, 1, 1, 1, 16'h8888, 16'hA000, 8'h0C);
    // Flush does not release writers already past the stage
    tbl[25] = mk(1, 2, 2, 10, 1, 8'h0D, 0, 0, 0, 0, 1, 1, 1, 16'hA002, 16'hA002, 8'h0D);
    tbl[26] = mk(1, 1, 1, 11, 0, 8'h0E, 0, 0, 0, 0, 1, 1, 1, 16'hA001, 16'hA001, 8'h0E);
    tbl[27] = mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[28] = mk(1, 10, 0, 0, 0, 8'h0F, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[29] = mk(1, 10, 0, 0, 0, 8'h0F, 1, 10, 16'hAAAA, 0, 1, 1, 1, 16'hAAAA, 16'hA000, 8'h0F);

    // ---------------- reset state ----------------
    reset_n = 1'b0;
    drive(1, 1, 2, 3, 1, 8'h55, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clock);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_a", out_a, 0);
    check("reset_out_op", out_op, 0);
    check("reset_out_rd_en", out_rd_en, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // ---------------- directed table ----------------
    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].iv, tbl[i].ra, tbl[i].rb, tbl[i].rd, tbl[i].rde, tbl[i].op,
            tbl[i].wbv, tbl[i].wba, tbl[i].wbd, tbl[i].fl, tbl[i].ordy);
      #2;
      check($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      check($sformatf("vec%0d_rd_addr_a", i), reg_r_a_addr, tbl[i].ra);
      check($sformatf("vec%0d_rd_addr_b", i), reg_r_b_addr, tbl[i].rb);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        check($sformatf("vec%0d_out_a", i), out_a, tbl[i].e_a);
        check($sformatf("vec%0d_out_b", i), out_b, tbl[i].e_b);
        check($sformatf("vec%0d_out_op", i), out_op, tbl[i].e_op);
      end
      $display("vec %0d: in_ready=%0b out_valid=%0b out_a=%h out_b=%h out_op=%h",
               i, in_ready, out_valid, out_a, out_b, out_op);
    end

    // ---------------- async reset mid-stall ----------------
    drive(1, 1, 1, 2, 1, 8'h10, 0, 0, 0, 0, 1);
    #2;
    check("arst_setup_ready", in_ready, 1);
    @(posedge clock);
    #1;
    check("arst_setup_valid", out_valid, 1);
    drive(1, 2, 0, 0, 0, 8'h11, 0, 0, 0, 0, 1);
    #2;
    check("arst_stall_ready", in_ready, 0);
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_out_a", out_a, 0);
    check("arst_out_b", out_b, 0);
    check("arst_out_rd", out_rd, 0);
    check("arst_out_rd_en", out_rd_en, 0);
    check("arst_out_op", out_op, 0);
    #1;
    reset_n = 1'b1;
    #1;
    check("arst_release_ready", in_ready, 1);
    @(posedge clock);
    #1;
    check("arst_accept_valid", out_valid, 1);
    check("arst_accept_a", out_a, 16'hA002);
    check("arst_accept_op", out_op, 8'h11);
    $display("arst: out_valid=%0b out_a=%h out_op=%h", out_valid, out_a, out_op);

    // ---------------- randomized run vs reference model ----------------
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) m_busy[i] = 0;
    m_sv = 0; m_sa = 0; m_sb = 0; m_srd = 0; m_srde = 0; m_sop = 0;
    pend.delete();

    for (int cyc = 0; cyc < 2000; cyc++) begin
      iv   = ($urandom_range(0, 9) < 7);
      ra   = 4'($urandom_range(0, 15));
      rb   = 4'($urandom_range(0, 15));
      rd   = 4'($urandom_range(0, 15));
      rde  = 1'($urandom_range(0, 1));
      op   = 8'($urandom_range(0, 255));
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      wbd  = 16'($urandom_range(0, 65535));
      wbv  = 0;
      wba  = 0;
      if (pend.size() > 0 && $urandom_range(0, 9) < 4) begin
        idx = $urandom_range(0, pend.size() - 1);
        wba = 4'(pend[idx]);
        pend.delete(idx);
        wbv = 1;
      end else if ($urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, 15);
        if (!m_busy[r]) begin
          wbv = 1;
          wba = 4'(r);
        end
      end

      // Expected behaviour from the stage's rules.
      erdy = !fl && (!m_sv || ordy)
             && !(m_busy[ra] && !(wbv && wba == ra))
             && !(m_busy[rb] && !(wbv && wba == rb))
             && !(rde && m_busy[rd] && !(wbv && wba == rd));
      acc  = iv && erdy;
      ea   = (wbv && wba == ra) ? wbd : rf[ra];
      eb   = (wbv && wba == rb) ? wbd : rf[rb];

      drive(iv, ra, rb, rd, rde, op, wbv, wba, wbd, fl, ordy);
      #2;
      check("rnd_in_ready", in_ready, erdy);
      check("rnd_rd_addr_a", reg_r_a_addr, ra);
      @(posedge clock);

      if (m_sv && fl && m_srde) m_busy[m_srd] = 0;
      else if (m_sv && ordy && !fl && m_srde) pend.push_back(int'(m_srd));
      if (wbv) m_busy[wba] = 0;
      if (acc) begin
        if (rde) m_busy[rd] = 1;
        m_sv = 1; m_sa = ea; m_sb = eb; m_srd = rd; m_srde = rde; m_sop = op;
      end else if (fl || ordy) begin
        m_sv = 0;
      end

      #1;
      check("rnd_out_valid", out_valid, m_sv);
      if (m_sv) begin
        check("rnd_out_a", out_a, m_sa);
        check("rnd_out_b", out_b, m_sb);
        check("rnd_out_rd", out_rd, m_srd);
        check("rnd_out_rd_en", out_rd_en, m_srde);
        check("rnd_out_op", out_op, m_sop);
      end
      $display("rnd %0d: acc=%0b in_ready=%0b out_valid=%0b out_a=%h out_b=%h out_op=%h",
               cyc, acc, in_ready, out_valid, out_a, out_b, out_op);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
